ddr3_frame_wr_sched: RTL and testbench

- Schedules DDR3 write-back of completed subframe buffers for the DDR3 cache controller.
- Several producer channels post "subframe ready" requests; a round-robin arbiter picks one.
- The block computes the subframe's DDR3 base address from frame/subframe/startframe.
- It then issues a fixed train of burst write commands that covers the 32 KiB subframe region, and signals completion per channel.

---
 rtl/ddr3_frame_wr_sched.sv | 158 +++++++++++++++
 tb/tb_ddr3_frame_wr_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_frame_wr_sched.sv
// DDR3 subframe write-back scheduler: round-robin grant, base calc,
// fixed burst train over the 32 KiB subframe, per-channel done.
// Ports: clk, rst_n (async low); startframe, req_valid/frame/subframe
// in; req_ack out; cmd_valid/addr/last out, cmd_ready in;
// done/done_id, busy, err out.
// Option: FRAME_SCHED_RANGE_CHK_EN rejects subframe > 9 with err.
module ddr3_frame_wr_sched #(
  parameter int NREQ        = 4,
  parameter int BURST_BYTES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             startframe,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [16*NREQ-1:0]      req_frame,
  input  logic [4*NREQ-1:0]       req_subframe,
  output logic [NREQ-1:0]         req_ack,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [31:0]             cmd_addr,
  output logic                    cmd_last,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic                    busy,
  output logic                    err
);

  localparam int GW     = $clog2(NREQ);
  localparam int NBURST = 32768 / BURST_BYTES;
  localparam int CW     = (NBURST > 1) ? $clog2(NBURST) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ISSUE, S_DONE, S_ERR
  } st_t;

  st_t r_st, w_nxt;

  logic [GW-1:0] r_ptr, r_g, w_g;
  logic          w_any, w_bad, w_grant, w_last;
  logic [15:0]   w_frm, w_diff;
  logic [3:0]    w_sub, r_sub;
  logic [9:0]    r_frm, r_rel;
  logic [15:0]   r_sf;
  logic [1:0]    r_cc;
  logic [13:0]   r_idx;
  logic [31:0]   r_base, w_addr;
  logic [CW-1:0] r_cnt;
  logic          w_unused;
  int            j;

  // first requester at or after the pointer, wrapping
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (!w_any && req_valid[j]) begin
        w_any = 1'b1;
        w_g   = GW'(j);
      end
    end
  end

  assign w_frm   = req_frame[16*w_g +: 16];
  assign w_sub   = req_subframe[4*w_g +: 4];
  assign w_grant = rst_n && (r_st == S_IDLE) && w_any;

`ifdef FRAME_SCHED_RANGE_CHK_EN
  assign w_bad = (w_sub > 4'd9);
`else
  assign w_bad = 1'b0;
`endif

  // +1024 bias keeps the wrap case positive; only 10 bits survive
  assign w_diff   = {6'b000001, r_frm} - r_sf;
  assign w_last   = (r_cnt == CW'(NBURST - 1));
  assign w_addr   = r_base + 32'(r_cnt) * 32'(BURST_BYTES);
  assign w_unused = ^{w_diff[15:10], w_frm[15:10]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= S_IDLE;
    else        r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      S_IDLE:  if (w_any) w_nxt = w_bad ? S_ERR : S_CALC;
      S_CALC:  if (r_cc == 2'd2) w_nxt = S_ISSUE;
      S_ISSUE: if (cmd_ready && w_last) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      S_ERR:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ack         = '0;
    if (w_grant)
      req_ack[w_g]  = 1'b1;
    cmd_valid       = (r_st == S_ISSUE);
    cmd_addr        = cmd_valid ? w_addr : 32'd0;
    cmd_last        = cmd_valid && w_last;
    done            = (r_st == S_DONE);
    done_id         = done ? r_g : '0;
    busy            = (r_st != S_IDLE);
`ifdef FRAME_SCHED_RANGE_CHK_EN
    err             = (r_st == S_ERR);
`else
    err             = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_g    <= '0;
      r_frm  <= '0;
      r_sub  <= '0;
      r_sf   <= '0;
      r_cc   <= '0;
      r_rel  <= '0;
      r_idx  <= '0;
      r_base <= '0;
      r_cnt  <= '0;
    end else begin
      unique case (r_st)
        S_IDLE: begin
          if (w_any) begin
            r_g   <= w_g;
            r_frm <= w_frm[9:0];
            r_sub <= w_sub;
            r_sf  <= startframe;
            r_cc  <= '0;
            r_ptr <= (w_g == GW'(NREQ - 1)) ? '0 : w_g + 1'b1;
          end
        end
        S_CALC: begin
          r_cc  <= r_cc + 2'd1;
          r_cnt <= '0;
          if (r_cc == 2'd0)
            r_rel <= w_diff[9:0];
          if (r_cc == 2'd1)
            r_idx <= 14'(r_rel) * 14'd10 + 14'(r_sub);
          if (r_cc == 2'd2)
            r_base <= {3'b000, r_idx, 15'b0};
        end
        S_ISSUE: begin
          if (cmd_ready)
            r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_frame_wr_sched.sv
// Directed bench for ddr3_frame_wr_sched: vector table of single
// transactions plus round-robin, reset-abort and subframe-range cases.
module tb_ddr3_frame_wr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] startframe;
  logic [3:0]  req_valid;
  logic [63:0] req_frame;
  logic [15:0] req_subframe;
  logic [3:0]  req_ack;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_last;
  logic        done;
  logic [1:0]  done_id;
  logic        busy;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  ddr3_frame_wr_sched #(.NREQ(4), .BURST_BYTES(4096)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .startframe   (startframe),
    .req_valid    (req_valid),
    .req_frame    (req_frame),
    .req_subframe (req_subframe),
    .req_ack      (req_ack),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_last     (cmd_last),
    .done         (done),
    .done_id      (done_id),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [15:0] fr;
    logic [3:0]  sb;
    logic [15:0] sf;
    logic [31:0] base;
    bit          stall;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input int ch, input logic [15:0] fr,
                         input logic [3:0] sb, input logic [15:0] sf,
                         input logic [31:0] base, input bit stall,
                         input int abort_k);
    bit got;
    int lat, k, cyc;
    @(posedge clk); #1;
    req_frame[16*ch +: 16]  = fr;
    req_subframe[4*ch +: 4] = sb;
    startframe              = sf;
    req_valid[ch]           = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      if (req_ack != 4'd0) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_onehot", 32'(req_ack), 32'd1 << ch);
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
    cmd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    lat = 0;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      lat++;
      if (cmd_valid) break;
    end
    chk("latency", 32'(lat), 32'd4);
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 400) begin
      if (k == abort_k) begin
        req_valid[ch] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_addr", cmd_addr, 32'd0);
        chk("rst_last", 32'(cmd_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      chk("cmd_valid", 32'(cmd_valid), 32'd1);
      chk("cmd_addr", cmd_addr, base + 32'(k) * 32'd4096);
      chk("cmd_last", 32'(cmd_last), 32'(k == 7));
      chk("no_early_done", 32'(done), 32'd0);
      if (cmd_ready && cmd_valid) k++;
      @(posedge clk); #1;
      cmd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk("handshakes", 32'(k), 32'd8);
    chk("done", 32'(done), 32'd1);
    chk("done_id", 32'(done_id), 32'(ch));
    chk("valid_off", 32'(cmd_valid), 32'd0);
    chk("err_quiet", 32'(err), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, cyc, g;
    bit prev_done;
    bit got;

    tbl[0] = '{0, 16'h0005, 4'd3, 16'h0400, 32'h001A_8000, 1'b0};
    tbl[1] = '{1, 16'h0003, 4'd0, 16'h03FE, 32'h0019_0000, 1'b0};
    tbl[2] = '{2, 16'h0C10, 4'd9, 16'h0008, 32'h002C_8000, 1'b1};
    tbl[3] = '{3, 16'h03FF, 4'd9, 16'h0000, 32'h13FF_8000, 1'b0};
    tbl[4] = '{1, 16'h0100, 4'd0, 16'h0100, 32'h0000_0000, 1'b1};

    rst_n        = 1'b0;
    startframe   = '0;
    req_valid    = 4'b0001;
    req_frame    = '0;
    req_subframe = '0;
    cmd_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack_gated", 32'(req_ack), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_addr", cmd_addr, 32'd0);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_err0", 32'(err), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_txn(tbl[i].ch, tbl[i].fr, tbl[i].sb, tbl[i].sf,
              tbl[i].base, tbl[i].stall, -1);

    run_txn(1, 16'h0010, 4'd2, 16'h0000, 32'h0051_0000, 1'b0, 4);
    run_txn(1, 16'h0010, 4'd2, 16'h0000, 32'h0051_0000, 1'b0, -1);

    // round robin from a fresh pointer with all channels held high
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    req_valid = 4'hF;
    n = 0;
    cyc = 0;
    prev_done = 1'b0;
    while (n < 5 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (done) chk("no_ack_in_done", 32'(req_ack), 32'd0);
      if (prev_done) chk("ack_after_done", 32'(req_ack != 0), 32'd1);
      if (req_ack != 4'd0) begin
        chk("rr_onehot", 32'($countones(req_ack)), 32'd1);
        g = 0;
        for (int b = 0; b < 4; b++) if (req_ack[b]) g = b;
        chk("rr_order", 32'(g), 32'(n % 4));
        n++;
      end
      prev_done = done;
    end
    chk("rr_count", 32'(n), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      if (!busy) got = 1'b1;
    end
    chk("rr_drain", 32'(got), 32'd1);

`ifdef FRAME_SCHED_RANGE_CHK_EN
    @(posedge clk); #1;
    req_frame[15:0]   = 16'h0000;
    req_subframe[3:0] = 4'd12;
    startframe        = 16'h0000;
    req_valid[0]      = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge clk);
      if (req_ack != 4'd0) got = 1'b1;
    end
    chk("rng_ack", 32'(req_ack), 32'd1);
    chk("rng_err_early", 32'(err), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rng_err", 32'(err), 32'd1);
    chk("rng_no_cmd", 32'(cmd_valid), 32'd0);
    @(negedge clk);
    chk("rng_err_pulse", 32'(err), 32'd0);
    chk("rng_idle", 32'(busy), 32'd0);
    chk("rng_no_cmd2", 32'(cmd_valid), 32'd0);
    chk("rng_no_done", 32'(done), 32'd0);
`else
    run_txn(0, 16'h0000, 4'd12, 16'h0000, 32'h0006_0000, 1'b0, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
